maxnet_winner_encoder: RTL
==========================

# maxnet_winner_encoder

Sequential result stage that sits after the MaxNet neuron array. It samples the four post-ReLU neuron outputs once per completed competition iteration and decides when the competition has converged. On convergence it encodes the surviving neuron as a 2-bit index plus value, and delivers that result through a valid/ready handshake. All-zero collapse and (optionally) iteration timeout are reported as distinct outcomes.

## Interface
Parameters:
- DATA_W, 8, width of each unsigned neuron value
- MAX_ITER, 16, iteration limit when timeout is compiled in (≥2)
- CNT_W, 5, width of iter_count (must hold MAX_ITER)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new watch; honoured only in IDLE
- iter_valid  in  1  one-cycle pulse: x0..x3 hold a finished iteration
- x0, x1, x2, x3  in  DATA_W each  neuron outputs (unsigned, already ReLU'd)
- out_ready  in  1  consumer accepts result
- out_valid  out  1  result held stable until accepted
- winner_idx  out  2  index of surviving neuron
- winner_val  out  DATA_W  value of surviving neuron
- no_winner  out  1  all neurons reached zero in the same iteration
- timeout  out  1  MAX_ITER reached with >1 nonzero neuron
- busy  out  1  high in WATCH and HOLD
- iter_count  out  CNT_W  iterations observed in current watch

## Operation
- Per-neuron nonzero flag nz[i] = OR-reduction of xi; nz is a 4-bit mask; popcount computed combinationally.
- FSM states: IDLE, WATCH, HOLD.
- IDLE: start=1 → WATCH; iter_count cleared to 0, result flags cleared. iter_valid ignored.
- WATCH, on iter_valid=1 (priority order):
  - popcount==1 → latch winner_idx = position of set bit, winner_val = that xi; no_winner=0; → HOLD.
  - popcount==0 → winner_idx=0, winner_val=0, no_winner=1; → HOLD.
  - timeout compiled in and iter_count==MAX_ITER-1 → timeout=1, winner_idx = lowest-index nonzero neuron, winner_val = its value; → HOLD.
  - otherwise iter_count+1, stay in WATCH.
- WATCH, iter_valid=0: hold state. start in WATCH ignored.
- HOLD: out_valid=1; winner_idx, winner_val, no_winner, timeout, iter_count frozen. out_ready=1 → IDLE; out_valid falls on the same edge. start in HOLD ignored (including the acceptance cycle).
- iter_count saturates; it never wraps.
- Reset (any state, mid-watch included): immediately to IDLE, pending result discarded.

## Timing
- Reset values: out_valid=0, winner_idx=0, winner_val=0, no_winner=0, timeout=0, busy=0, iter_count=0, state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- start sampled at edge t → busy=1 from t.
- Converging iter_valid sampled at edge t → out_valid=1 from t (one-cycle latency).
- If out_ready is held high, the transfer occurs at edge t+1 and out_valid=0 from t+1.
- Minimum turnaround: a new start is accepted one cycle after acceptance (IDLE).
- x0..x3 are sampled only on cycles with iter_valid=1 in WATCH; their values in other cycles are don't-care.

## Configuration
- MAXNET_WINNER_TIMEOUT_EN defined: MAX_ITER limit active, timeout output driven as above.
- Not defined: no limit check, timeout tied to 0, WATCH persists until single-winner or all-zero; iter_count still counts and saturates at 2^CNT_W-1.

## Test plan
- start; iter_valid with x=(40,30,20,10), then (25,5,0,0), then (22,0,0,0) → out_valid next edge, winner_idx=0, winner_val=22, iter_count=2, no_winner=0, timeout=0.
- start; iter_valid with x=(0,0,0,0) → no_winner=1, winner_idx=0, winner_val=0, out_valid=1.
- Result pending with out_ready=0 for 5 cycles; start and iter_valid with x=(0,9,0,0) pulsed meanwhile → outputs unchanged, out_valid stays 1; out_ready=1 → out_valid=0 next edge, busy=0.
- MAXNET_WINNER_TIMEOUT_EN with MAX_ITER=4: feed (5,5,5,5) on 4 iter_valids → timeout=1, winner_idx=0, winner_val=5, iter_count=3. Without the macro: still in WATCH, timeout=0.
- Assert rst mid-WATCH after 2 iterations → all outputs 0 asynchronously. A following start plus x=(0,0,7,0) gives winner_idx=2, winner_val=7, iter_count=0.

Source files
------------

// File: rtl/maxnet_winner_encoder.sv
// MaxNet result stage: watches post-ReLU neuron outputs per iteration and encodes the survivor.
// Latency: result registered one cycle after the converging iter_valid edge; held in HOLD until out_ready.
// Backpressure: out_valid/payload frozen while out_ready=0; start and iter_valid are ignored outside IDLE/WATCH.
// Optional iteration limit: define MAXNET_WINNER_TIMEOUT_EN to enable the MAX_ITER timeout outcome.
module maxnet_winner_encoder #(
  parameter int DATA_W   = 8,
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              iter_valid,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        winner_idx,
  output logic [DATA_W-1:0] winner_val,
  output logic              no_winner,
  output logic              timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  iter_count
);

`ifdef MAXNET_WINNER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, WATCH, HOLD} state_t;

  state_t            state, state_nx;
  logic [3:0]        nz;
  logic [2:0]        pop;
  logic [1:0]        low_idx;
  logic [DATA_W-1:0] low_val;
  logic              last_iter;
  logic              converge;
  logic [CNT_W-1:0]  cnt_inc;

  logic [1:0]        idx_nx;
  logic [DATA_W-1:0] val_nx;
  logic              nw_nx;
  logic              to_nx;
  logic [CNT_W-1:0]  cnt_nx;

  // Nonzero mask, survivor count and lowest-index nonzero neuron (equals the single survivor when pop==1)
  always_comb begin
    nz  = {|x3, |x2, |x1, |x0};
    pop = {2'b00, nz[0]} + {2'b00, nz[1]} + {2'b00, nz[2]} + {2'b00, nz[3]};
    low_idx = 2'd0;
    low_val = x0;
    if (nz[0]) begin
      low_idx = 2'd0;
      low_val = x0;
    end else if (nz[1]) begin
      low_idx = 2'd1;
      low_val = x1;
    end else if (nz[2]) begin
      low_idx = 2'd2;
      low_val = x2;
    end else if (nz[3]) begin
      low_idx = 2'd3;
      low_val = x3;
    end
    last_iter = TIMEOUT_EN && (iter_count == LAST_ITER);
    converge  = (pop <= 3'd1) || last_iter;
    cnt_inc   = (iter_count == CNT_MAX) ? iter_count : iter_count + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = WATCH;
      WATCH:   if (iter_valid && converge) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the result registers; held unless a start or iteration updates them
  always_comb begin
    idx_nx = winner_idx;
    val_nx = winner_val;
    nw_nx  = no_winner;
    to_nx  = timeout;
    cnt_nx = iter_count;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nx = 2'd0;
          val_nx = '0;
          nw_nx  = 1'b0;
          to_nx  = 1'b0;
          cnt_nx = '0;
        end
      end
      WATCH: begin
        if (iter_valid) begin
          if (pop == 3'd1) begin
            idx_nx = low_idx;
            val_nx = low_val;
            nw_nx  = 1'b0;
          end else if (pop == 3'd0) begin
            idx_nx = 2'd0;
            val_nx = '0;
            nw_nx  = 1'b1;
          end else if (last_iter) begin
            idx_nx = low_idx;
            val_nx = low_val;
            to_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // Result and status registers; out_valid/busy follow the next state so they change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      winner_idx <= 2'd0;
      winner_val <= '0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
      iter_count <= '0;
    end else begin
      out_valid  <= (state_nx == HOLD);
      busy       <= (state_nx != IDLE);
      winner_idx <= idx_nx;
      winner_val <= val_nx;
      no_winner  <= nw_nx;
      timeout    <= to_nx;
      iter_count <= cnt_nx;
    end
  end

endmodule
